// File: rtl/i2c_reg_ctrl_if.sv
// Request/response and I2C-master command bus of the register-access controller.
// The slave modport is the controller's view; master is the surrounding system.
interface i2c_reg_ctrl_if;
    logic       req_valid;
    logic       req_ready;
    logic       req_rnw;
    logic [6:0] req_dev;
    logic [7:0] req_reg;
    logic [7:0] req_wdata;

    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       rsp_nak;

    logic [1:0] m_cmd;
    logic [7:0] m_data;
    logic       m_ack;
    logic       m_stb;
    logic [7:0] m_data_in;
    logic       m_ack_in;
    logic       m_ready;

    modport slave (
        input  req_valid, req_rnw, req_dev, req_reg, req_wdata,
        input  m_data_in, m_ack_in, m_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_nak,
        output m_cmd, m_data, m_ack, m_stb
    );

    modport master (
        output req_valid, req_rnw, req_dev, req_reg, req_wdata,
        output m_data_in, m_ack_in, m_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_nak,
        input  m_cmd, m_data, m_ack, m_stb
    );
endinterface

// File: rtl/i2c_reg_ctrl.sv
// Sequences single-register I2C writes and reads as a list of byte-level
// commands handed one at a time to an external I2C master.
//
// state | meaning
// IDLE  | ready for a request
// ISSUE | waiting for m_ready, then strobe the current step
// GAP   | one cycle after the strobe, master status not trusted yet
// WAIT  | waiting for the master to finish the step
// RESP  | one-cycle completion pulse
module i2c_reg_ctrl (
    input  logic           clk,
    input  logic           rst_n,
    i2c_reg_ctrl_if.slave  bus
);
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_ISSUE = 3'd1;
    localparam logic [2:0] ST_GAP   = 3'd2;
    localparam logic [2:0] ST_WAIT  = 3'd3;
    localparam logic [2:0] ST_RESP  = 3'd4;

    localparam logic [1:0] CMD_START = 2'b00;
    localparam logic [1:0] CMD_STOP  = 2'b01;
    localparam logic [1:0] CMD_WRITE = 2'b10;
    localparam logic [1:0] CMD_READ  = 2'b11;

    logic [2:0] state;
    logic [2:0] step;
    logic       ready_q;
    logic       rnw_q;
    logic [6:0] dev_q;
    logic [7:0] reg_q;
    logic [7:0] wdata_q;
    logic       nak_q;
    logic [7:0] rdata_q;
    logic [1:0] cmd_q;
    logic [7:0] data_q;
    logic       ack_q;
    logic       stb_q;

    logic [1:0] step_cmd;
    logic [7:0] step_data;
    logic       step_ack;
    logic [2:0] last_step;
    logic       accept;

    assign last_step = rnw_q ? 3'd6 : 3'd4;
    assign accept    = bus.req_valid && ready_q;

    // Write: START, {dev,0}, reg, wdata, STOP
    // Read:  START, {dev,0}, reg, START, {dev,1}, READ+NACK, STOP
    always_comb begin
        step_cmd  = CMD_STOP;
        step_data = 8'h00;
        step_ack  = 1'b0;
        case (step)
            3'd0: step_cmd = CMD_START;
            3'd1: begin
                step_cmd  = CMD_WRITE;
                step_data = {dev_q, 1'b0};
            end
            3'd2: begin
                step_cmd  = CMD_WRITE;
                step_data = reg_q;
            end
            3'd3: begin
                if (rnw_q) begin
                    step_cmd = CMD_START;
                end else begin
                    step_cmd  = CMD_WRITE;
                    step_data = wdata_q;
                end
            end
            3'd4: begin
                if (rnw_q) begin
                    step_cmd  = CMD_WRITE;
                    step_data = {dev_q, 1'b1};
                end
            end
            3'd5: begin
                if (rnw_q) begin
                    step_cmd = CMD_READ;
                    step_ack = 1'b1;
                end
            end
            default: step_cmd = CMD_STOP;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            step    <= 3'd0;
            ready_q <= 1'b0;
            rnw_q   <= 1'b0;
            dev_q   <= 7'h00;
            reg_q   <= 8'h00;
            wdata_q <= 8'h00;
            nak_q   <= 1'b0;
            rdata_q <= 8'h00;
            cmd_q   <= CMD_START;
            data_q  <= 8'h00;
            ack_q   <= 1'b0;
            stb_q   <= 1'b0;
        end else begin
            stb_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        rnw_q   <= bus.req_rnw;
                        dev_q   <= bus.req_dev;
                        reg_q   <= bus.req_reg;
                        wdata_q <= bus.req_wdata;
                        step    <= 3'd0;
                        nak_q   <= 1'b0;
                        ready_q <= 1'b0;
                        state   <= ST_ISSUE;
                    end else begin
                        ready_q <= 1'b1;
                    end
                end
                ST_ISSUE: begin
                    if (bus.m_ready) begin
                        stb_q  <= 1'b1;
                        cmd_q  <= step_cmd;
                        data_q <= step_data;
                        ack_q  <= step_ack;
                        state  <= ST_GAP;
                    end
                end
                ST_GAP: state <= ST_WAIT;
                ST_WAIT: begin
                    if (bus.m_ready) begin
                        if (cmd_q == CMD_READ) begin
                            rdata_q <= bus.m_data_in;
                        end
                        if (step == last_step) begin
                            state <= ST_RESP;
                        end else begin
                            state <= ST_ISSUE;
                            // A NACKed byte jumps straight to the closing STOP.
                            if (cmd_q == CMD_WRITE && bus.m_ack_in) begin
                                nak_q <= 1'b1;
                                step  <= last_step;
                            end else begin
                                step <= step + 3'd1;
                            end
                        end
                    end
                end
                ST_RESP: begin
                    ready_q <= 1'b1;
                    state   <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.req_ready = ready_q;
    assign bus.rsp_valid = (state == ST_RESP);
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_nak   = nak_q;
    assign bus.m_cmd     = cmd_q;
    assign bus.m_data    = data_q;
    assign bus.m_ack     = ack_q;
    assign bus.m_stb     = stb_q;
endmodule

// File: tb/tb_i2c_reg_ctrl.sv
// Directed bench for i2c_reg_ctrl with a small behavioural I2C master that
// logs every strobe and completion.
module tb_i2c_reg_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    i2c_reg_ctrl_if bus();

    i2c_reg_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    logic       mdl_ready = 1'b1;
    logic       hold = 1'b0;
    int         busy = 0;
    int         nak_idx = -1;
    logic [7:0] rd_byte = 8'h00;
    assign bus.m_ready = mdl_ready && !hold;

    logic [1:0] log_cmd  [128];
    logic [7:0] log_data [128];
    logic       log_ack  [128];
    int         n_stb = 0;
    logic       log_nak   [16];
    logic [7:0] log_rdata [16];
    int         rsp_cyc   [16];
    int         n_rsp = 0;
    int         acc_cyc   [16];
    int         n_acc = 0;
    int         cyc = 0;
    int         unstable = 0;
    logic       have_last = 1'b0;
    logic [10:0] last_out = '0;

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            mdl_ready     = 1'b1;
            busy          = 0;
            have_last     = 1'b0;
            bus.m_ack_in  = 1'b0;
            bus.m_data_in = 8'h00;
        end else begin
            if (bus.m_stb) begin
                if (n_stb < 128) begin
                    log_cmd[n_stb]  = bus.m_cmd;
                    log_data[n_stb] = bus.m_data;
                    log_ack[n_stb]  = bus.m_ack;
                end
                last_out     = {bus.m_cmd, bus.m_data, bus.m_ack};
                have_last    = 1'b1;
                bus.m_ack_in = (n_stb == nak_idx);
                n_stb++;
                mdl_ready = 1'b0;
                busy      = 2;
            end else begin
                if (have_last && ({bus.m_cmd, bus.m_data, bus.m_ack} !== last_out))
                    unstable++;
                if (busy > 0) begin
                    busy--;
                    if (busy == 0) begin
                        mdl_ready     = 1'b1;
                        bus.m_data_in = rd_byte;
                    end
                end
            end
            if (bus.rsp_valid && n_rsp < 16) begin
                log_nak[n_rsp]   = bus.rsp_nak;
                log_rdata[n_rsp] = bus.rsp_rdata;
                rsp_cyc[n_rsp]   = cyc;
                n_rsp++;
            end
            if (bus.req_valid && bus.req_ready && n_acc < 16) begin
                acc_cyc[n_acc] = cyc;
                n_acc++;
            end
        end
    end

    task automatic drive_req(input logic rnw, input logic [6:0] dev, input logic [7:0] rg,
                             input logic [7:0] wd);
        bus.req_rnw   = rnw;
        bus.req_dev   = dev;
        bus.req_reg   = rg;
        bus.req_wdata = wd;
    endtask

    task automatic send(input logic rnw, input logic [6:0] dev, input logic [7:0] rg,
                        input logic [7:0] wd);
        bit ok = 0;
        @(negedge clk);
        drive_req(rnw, dev, rg, wd);
        bus.req_valid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (bus.req_ready) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        chk("accept_timeout", 32'(ok), 1);
        @(negedge clk);
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int target);
        for (int i = 0; i < 400; i++) begin
            if (n_rsp >= target) break;
            @(negedge clk);
        end
        chk("rsp_timeout", 32'(n_rsp >= target), 1);
    endtask

    task automatic chk_stb(input string tag, input int idx, input logic [1:0] cmd,
                           input logic [7:0] data);
        chk({tag, "_cmd"}, 32'(log_cmd[idx]), 32'(cmd));
        if (cmd == 2'b10) chk({tag, "_data"}, 32'(log_data[idx]), 32'(data));
    endtask

    int sb, rb, ab;

    initial begin
        bus.req_valid = 1'b0;
        drive_req(1'b0, 7'h00, 8'h00, 8'h00);
        repeat (3) @(negedge clk);
        chk("rst_flags", {27'd0, bus.req_ready, bus.m_stb, bus.rsp_valid, bus.rsp_nak, bus.m_ack}, 0);
        chk("rst_rdata", 32'(bus.rsp_rdata), 0);
        chk("rst_cmd_data", {22'd0, bus.m_cmd, bus.m_data}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", 32'(bus.req_ready), 1);

        // Plain write, all bytes ACKed
        sb = n_stb; rb = n_rsp;
        send(1'b0, 7'h50, 8'h12, 8'hA5);
        wait_rsp(rb + 1);
        chk("wr_nstb", 32'(n_stb - sb), 5);
        chk_stb("wr0", sb + 0, 2'b00, 8'h00);
        chk_stb("wr1", sb + 1, 2'b10, 8'hA0);
        chk_stb("wr2", sb + 2, 2'b10, 8'h12);
        chk_stb("wr3", sb + 3, 2'b10, 8'hA5);
        chk_stb("wr4", sb + 4, 2'b01, 8'h00);
        chk("wr_nak", 32'(log_nak[rb]), 0);
        chk("wr_rdata", 32'(log_rdata[rb]), 8'h00);

        // Read returning 0x5A
        sb = n_stb; rb = n_rsp; rd_byte = 8'h5A;
        send(1'b1, 7'h50, 8'h34, 8'h00);
        wait_rsp(rb + 1);
        chk("rd_nstb", 32'(n_stb - sb), 7);
        chk_stb("rd0", sb + 0, 2'b00, 8'h00);
        chk_stb("rd1", sb + 1, 2'b10, 8'hA0);
        chk_stb("rd2", sb + 2, 2'b10, 8'h34);
        chk_stb("rd3", sb + 3, 2'b00, 8'h00);
        chk_stb("rd4", sb + 4, 2'b10, 8'hA1);
        chk_stb("rd5", sb + 5, 2'b11, 8'h00);
        chk("rd5_ack", 32'(log_ack[sb + 5]), 1);
        chk("rd1_ack", 32'(log_ack[sb + 1]), 0);
        chk_stb("rd6", sb + 6, 2'b01, 8'h00);
        chk("rd_nak", 32'(log_nak[rb]), 0);
        chk("rd_rdata", 32'(log_rdata[rb]), 8'h5A);

        // Write NACKed on the address byte
        sb = n_stb; rb = n_rsp; nak_idx = sb + 1; rd_byte = 8'hEE;
        send(1'b0, 7'h3C, 8'h01, 8'h77);
        wait_rsp(rb + 1);
        nak_idx = -1;
        chk("wnak_nstb", 32'(n_stb - sb), 3);
        chk_stb("wnak1", sb + 1, 2'b10, 8'h78);
        chk_stb("wnak2", sb + 2, 2'b01, 8'h00);
        chk("wnak_nak", 32'(log_nak[rb]), 1);
        chk("wnak_rdata", 32'(log_rdata[rb]), 8'h5A);

        // Read NACKed on the register byte
        sb = n_stb; rb = n_rsp; nak_idx = sb + 2;
        send(1'b1, 7'h50, 8'h99, 8'h00);
        wait_rsp(rb + 1);
        nak_idx = -1;
        chk("rnak_nstb", 32'(n_stb - sb), 4);
        chk_stb("rnak2", sb + 2, 2'b10, 8'h99);
        chk_stb("rnak3", sb + 3, 2'b01, 8'h00);
        chk("rnak_nak", 32'(log_nak[rb]), 1);
        chk("rnak_rdata", 32'(log_rdata[rb]), 8'h5A);

        // Master busy for 10 cycles before the first step
        sb = n_stb; rb = n_rsp; hold = 1'b1;
        send(1'b0, 7'h21, 8'h80, 8'h00);
        repeat (10) @(negedge clk);
        chk("stall_nostb", 32'(n_stb - sb), 0);
        hold = 1'b0;
        wait_rsp(rb + 1);
        chk("stall_nstb", 32'(n_stb - sb), 5);
        chk_stb("stall1", sb + 1, 2'b10, 8'h42);
        chk_stb("stall3", sb + 3, 2'b10, 8'h00);

        // Reset after the third strobe of a read
        sb = n_stb; rd_byte = 8'h11;
        send(1'b1, 7'h50, 8'h34, 8'h00);
        for (int i = 0; i < 100; i++) begin
            if (n_stb - sb >= 3) break;
            @(negedge clk);
        end
        chk("mid_three_stb", 32'(n_stb - sb), 3);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_flags", {29'd0, bus.req_ready, bus.m_stb, bus.rsp_valid}, 0);
        chk("mid_rst_rdata", 32'(bus.rsp_rdata), 8'h00);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        sb = n_stb; rb = n_rsp;
        @(negedge clk);
        chk("mid_ready", 32'(bus.req_ready), 1);
        repeat (30) @(negedge clk);
        chk("mid_no_stb", 32'(n_stb - sb), 0);
        chk("mid_no_rsp", 32'(n_rsp - rb), 0);
        rd_byte = 8'hC3;
        send(1'b1, 7'h50, 8'h34, 8'h00);
        wait_rsp(rb + 1);
        chk("post_nstb", 32'(n_stb - sb), 7);
        chk_stb("post4", sb + 4, 2'b10, 8'hA1);
        chk("post_rdata", 32'(log_rdata[rb]), 8'hC3);

        // Back-to-back with req_valid held
        sb = n_stb; rb = n_rsp; ab = n_acc; rd_byte = 8'h9E;
        @(negedge clk);
        drive_req(1'b0, 7'h11, 8'h22, 8'h33);
        bus.req_valid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (bus.req_ready) break;
            @(negedge clk);
        end
        @(negedge clk);
        drive_req(1'b1, 7'h11, 8'h44, 8'h00);
        for (int i = 0; i < 400; i++) begin
            if (bus.req_ready) break;
            @(negedge clk);
        end
        @(negedge clk);
        bus.req_valid = 1'b0;
        wait_rsp(rb + 2);
        chk("b2b_nacc", 32'(n_acc - ab), 2);
        chk("b2b_gap", 32'(acc_cyc[ab + 1] - rsp_cyc[rb]), 1);
        chk("b2b_nstb", 32'(n_stb - sb), 12);
        chk_stb("b2b_w3", sb + 3, 2'b10, 8'h33);
        chk_stb("b2b_r2", sb + 7, 2'b10, 8'h44);
        chk_stb("b2b_r5", sb + 10, 2'b11, 8'h00);
        chk("b2b_rdata0", 32'(log_rdata[rb]), 8'hC3);
        chk("b2b_rdata1", 32'(log_rdata[rb + 1]), 8'h9E);

        chk("cmd_stable", 32'(unstable), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/i2c_reg_ctrl.md
I2C_REG_CTRL -- requirements
Module: i2c_reg_ctrl

Interface
REQ-001 Block SHALL have no parameters.
REQ-002 clk  in  1  single clock; all logic on its rising edge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 req_valid  in  1  register-access request present.
REQ-005 req_ready  out  1  block idle, accepts request this cycle.
REQ-006 req_rnw  in  1  1=read, 0=write.
REQ-007 req_dev  in  7  I2C 7-bit device address.
REQ-008 req_reg  in  8  register address.
REQ-009 req_wdata  in  8  write data.
REQ-010 rsp_valid  out  1  one-cycle completion pulse.
REQ-011 rsp_rdata  out  8  read data, valid with rsp_valid.
REQ-012 rsp_nak  out  1  1=transfer aborted on NACK, valid with rsp_valid.
REQ-013 m_cmd  out  2  I2C master command: 00 START, 01 STOP, 10 WRITE, 11 READ.
REQ-014 m_data  out  8  byte to write.
REQ-015 m_ack  out  1  ack bit sent after READ (1=NACK).
REQ-016 m_stb  out  1  one-cycle command strobe to master.
REQ-017 m_data_in  in  8  byte returned by master after READ.
REQ-018 m_ack_in  in  1  ack bit sampled by master after WRITE (1=NACK).
REQ-019 m_ready  in  1  master idle.

Function
REQ-020 Request SHALL be accepted on the cycle where req_valid and req_ready are both 1; req_dev/req_reg/req_wdata/req_rnw SHALL be latched then.
REQ-021 req_ready SHALL be 1 only in IDLE.
REQ-022 Write sequence SHALL be: START; WRITE {dev,0}; WRITE reg; WRITE wdata; STOP.
REQ-023 Read sequence SHALL be: START; WRITE {dev,0}; WRITE reg; START; WRITE {dev,1}; READ with m_ack=1; STOP.
REQ-024 State machine SHALL be IDLE -> ISSUE -> GAP -> WAIT -> (ISSUE of next step | RESP) -> IDLE.
REQ-025 ISSUE: when m_ready=1, assert m_stb for exactly one cycle with m_cmd/m_data/m_ack of the current step, then go to GAP; while m_ready=0, hold in ISSUE with m_stb=0.
REQ-026 GAP SHALL last exactly one cycle, m_ready ignored, then go to WAIT.
REQ-027 WAIT: on m_ready=1 the step SHALL be complete; m_ack_in/m_data_in SHALL be sampled that cycle.
REQ-028 m_cmd/m_data/m_ack SHALL stay stable from the m_stb cycle until the next m_stb.
REQ-029 After a WRITE step with m_ack_in=1: sequence SHALL skip to STOP, set the NAK flag, and not issue any further START/WRITE/READ.
REQ-030 After READ step completion, m_data_in SHALL be stored into rsp_rdata.
REQ-031 After STOP completes, RESP SHALL assert rsp_valid for one cycle, then return to IDLE; rsp_nak=NAK flag.
REQ-032 rsp_rdata SHALL hold its value until the next read completes; on write or NAK it SHALL be unchanged.
REQ-033 A new request SHALL be accepted no earlier than the cycle after rsp_valid.
REQ-034 req_valid while not idle SHALL be ignored (no queueing).
REQ-035 Step index SHALL be a 3-bit counter reset to 0 on each accept; no wrap beyond the final STOP step.

Reset
REQ-036 On rst_n=0, state SHALL go to IDLE immediately.
REQ-037 On rst_n=0: req_ready=0 while asserted, m_stb=0, rsp_valid=0, rsp_nak=0, rsp_rdata=8'h00, m_cmd=2'b00, m_data=8'h00, m_ack=0.
REQ-038 After rst_n deasserts, req_ready SHALL be 1 on the first clock edge.
REQ-039 Reset mid-transfer SHALL abandon the sequence with no STOP issued and no rsp_valid.

Verification
REQ-040 Write dev=0x50 reg=0x12 data=0xA5, slave ACKs all -> strobes 00, 10/0xA0, 10/0x12, 10/0xA5, 01; rsp_valid with rsp_nak=0.
REQ-041 Read dev=0x50 reg=0x34, master returns 0x5A -> strobes 00, 10/0xA0, 10/0x34, 00, 10/0xA1, 11 with m_ack=1, 01; rsp_rdata=0x5A, rsp_nak=0.
REQ-042 Write, m_ack_in=1 on the address byte -> next strobe is 01 (STOP); rsp_nak=1, rsp_rdata unchanged.
REQ-043 m_ready held 0 for 10 cycles before a step -> m_stb stays 0 until m_ready=1; exactly one strobe per step.
REQ-044 rst_n pulsed low after the third strobe of a read -> no further strobes, no rsp_valid; next request runs a full sequence correctly.
REQ-045 Two back-to-back requests with req_valid held high -> second accepted the cycle after the first rsp_valid; both sequences complete in order.
